// File: rtl/perf_run_ctrl_pkg.sv
// perf_run_ctrl_pkg
//   Shared definitions for the PRC measurement sequencer: FSM state
//   encodings, result status codes and default field widths.
package perf_run_ctrl_pkg;

    localparam int PRC_CNT_WIDTH = 28;
    localparam int PRC_RUN_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RUN        = 3'd2,
        ST_CAPTURE    = 3'd3,
        ST_REPORT     = 3'd4
    } prc_state_t;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_TIMEOUT = 2'd1,
        STAT_ABORT   = 2'd2
    } prc_status_t;

endpackage

// File: rtl/perf_run_ctrl_stat_acc.sv
// perf_stat_acc
//   Campaign statistics accumulator: min/max of h2c counts and running
//   sums of h2c and h2b counts.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_clr                 restore initial statistics (min all-ones, rest 0)
//   i_upd                 fold i_h2b / i_h2c samples into the statistics
//   o_h2c_min/o_h2c_max   extrema of h2c samples
//   o_h2c_sum/o_h2b_sum   sums, RUN_WIDTH bits of headroom over a sample
module perf_stat_acc
    import perf_run_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = PRC_CNT_WIDTH,
    parameter int RUN_WIDTH = PRC_RUN_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clr,
    input  logic                           i_upd,
    input  logic [CNT_WIDTH-1:0]           i_h2b,
    input  logic [CNT_WIDTH-1:0]           i_h2c,
    output logic [CNT_WIDTH-1:0]           o_h2c_min,
    output logic [CNT_WIDTH-1:0]           o_h2c_max,
    output logic [CNT_WIDTH+RUN_WIDTH-1:0] o_h2c_sum,
    output logic [CNT_WIDTH+RUN_WIDTH-1:0] o_h2b_sum
);

    localparam int SUM_W = CNT_WIDTH + RUN_WIDTH;

    logic [CNT_WIDTH-1:0] r_min;
    logic [CNT_WIDTH-1:0] r_max;
    logic [SUM_W-1:0]     r_h2c_sum;
    logic [SUM_W-1:0]     r_h2b_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_min     <= '1;
            r_max     <= '0;
            r_h2c_sum <= '0;
            r_h2b_sum <= '0;
        end else if (i_clr) begin
            r_min     <= '1;
            r_max     <= '0;
            r_h2c_sum <= '0;
            r_h2b_sum <= '0;
        end else if (i_upd) begin
            if (i_h2c < r_min) r_min <= i_h2c;
            if (i_h2c > r_max) r_max <= i_h2c;
            r_h2c_sum <= r_h2c_sum + {{RUN_WIDTH{1'b0}}, i_h2c};
            r_h2b_sum <= r_h2b_sum + {{RUN_WIDTH{1'b0}}, i_h2b};
        end
    end

    assign o_h2c_min = r_min;
    assign o_h2c_max = r_max;
    assign o_h2c_sum = r_h2c_sum;
    assign o_h2b_sum = r_h2b_sum;

endmodule

// File: rtl/perf_run_ctrl.sv
// perf_run_ctrl
//   Sequences a campaign of partial-reconfiguration runs, tracking each run
//   from the monitor's edge strobes, capturing per-run cycle counts into
//   perf_stat_acc, enforcing a per-run timeout and presenting the summary
//   through a valid/ready handshake.
// Ports:
//   sys_clk, sys_reset            clock, async active-high reset
//   cfg_runs, cfg_timeout         campaign config, sampled on accepted arm
//   arm, abort                    campaign control pulses
//   h2b_start_pos/h2b_end_pos/h2c_end_pos  monitor strobes
//   h2b_cyc_cnt, h2c_cyc_cnt      monitor counts (valid the cycle after end)
//   busy, run_idx                 campaign progress
//   res_valid/res_ready           summary handshake
//   res_runs, res_status, res_h2c_min/max, res_h2c_sum, res_h2b_sum  summary
module perf_run_ctrl
    import perf_run_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = PRC_CNT_WIDTH,
    parameter int RUN_WIDTH = PRC_RUN_WIDTH
) (
    input  logic                           sys_clk,
    input  logic                           sys_reset,
    input  logic [RUN_WIDTH-1:0]           cfg_runs,
    input  logic [CNT_WIDTH-1:0]           cfg_timeout,
    input  logic                           arm,
    input  logic                           abort,
    input  logic                           h2b_start_pos,
    input  logic                           h2b_end_pos,
    input  logic                           h2c_end_pos,
    input  logic [CNT_WIDTH-1:0]           h2b_cyc_cnt,
    input  logic [CNT_WIDTH-1:0]           h2c_cyc_cnt,
    output logic                           busy,
    output logic [RUN_WIDTH-1:0]           run_idx,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [RUN_WIDTH-1:0]           res_runs,
    output logic [1:0]                     res_status,
    output logic [CNT_WIDTH-1:0]           res_h2c_min,
    output logic [CNT_WIDTH-1:0]           res_h2c_max,
    output logic [CNT_WIDTH+RUN_WIDTH-1:0] res_h2c_sum,
    output logic [CNT_WIDTH+RUN_WIDTH-1:0] res_h2b_sum
);

    prc_state_t           r_state;
    prc_status_t          r_status;
    logic                 r_busy;
    logic                 r_res_valid;
    logic [RUN_WIDTH-1:0] r_runs_eff;
    logic [CNT_WIDTH-1:0] r_timeout;
    logic [RUN_WIDTH-1:0] r_run_idx;
    logic [RUN_WIDTH-1:0] r_res_runs;
    logic [CNT_WIDTH-1:0] r_to_cnt;
    logic                 r_h2b_seen;
    logic                 r_h2c_seen;
    logic                 r_h2b_pend;   // h2b count becomes valid this cycle
    logic                 r_h2b_lat;    // r_h2b_cnt holds this run's count
    logic [CNT_WIDTH-1:0] r_h2b_cnt;

    logic                 w_done;
    logic                 w_last;
    logic                 w_acc_clr;
    logic                 w_acc_upd;
    logic [CNT_WIDTH-1:0] w_h2b_smp;
    logic [RUN_WIDTH-1:0] w_runs_eff;

    assign w_runs_eff = (cfg_runs == '0) ? RUN_WIDTH'(1) : cfg_runs;
    // Strobes count in the cycle they arrive, so both orders and the
    // same-cycle case all reach CAPTURE one cycle after the last strobe.
    assign w_done     = (r_h2b_seen | h2b_end_pos) & (r_h2c_seen | h2c_end_pos);
    assign w_last     = (r_run_idx + RUN_WIDTH'(1)) == r_runs_eff;
    assign w_acc_clr  = (r_state == ST_IDLE) && arm;
    assign w_acc_upd  = (r_state == ST_CAPTURE);
    // If h2b ended on the completing cycle its count is only valid now.
    assign w_h2b_smp  = r_h2b_lat ? r_h2b_cnt : h2b_cyc_cnt;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_state     <= ST_IDLE;
            r_status    <= STAT_OK;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_runs_eff  <= RUN_WIDTH'(1);
            r_timeout   <= '0;
            r_run_idx   <= '0;
            r_res_runs  <= '0;
            r_to_cnt    <= '0;
            r_h2b_seen  <= 1'b0;
            r_h2c_seen  <= 1'b0;
            r_h2b_pend  <= 1'b0;
            r_h2b_lat   <= 1'b0;
            r_h2b_cnt   <= '0;
        end else begin
            r_h2b_pend <= (r_state == ST_RUN) && h2b_end_pos;
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_runs_eff <= w_runs_eff;
                        r_timeout  <= cfg_timeout;
                        r_run_idx  <= '0;
                        r_res_runs <= '0;
                        r_status   <= STAT_OK;
                        r_busy     <= 1'b1;
                        r_state    <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (abort) begin
                        r_status    <= STAT_ABORT;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end else if (h2b_start_pos) begin
                        r_h2b_seen <= 1'b0;
                        r_h2c_seen <= 1'b0;
                        r_h2b_lat  <= 1'b0;
                        r_to_cnt   <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_to_cnt <= r_to_cnt + CNT_WIDTH'(1);
                    if (h2b_end_pos) r_h2b_seen <= 1'b1;
                    if (h2c_end_pos) r_h2c_seen <= 1'b1;
                    if (r_h2b_pend) begin
                        r_h2b_cnt <= h2b_cyc_cnt;
                        r_h2b_lat <= 1'b1;
                    end
                    if (abort) begin
                        r_status    <= STAT_ABORT;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end else if (w_done) begin
                        r_state <= ST_CAPTURE;
                    end else if ((r_timeout != '0) && (r_to_cnt == r_timeout)) begin
                        r_status    <= STAT_TIMEOUT;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end
                end
                ST_CAPTURE: begin
                    // The accumulator commits this run on the same edge.
                    r_res_runs <= r_res_runs + RUN_WIDTH'(1);
                    if (abort || w_last) begin
                        if (abort) r_status <= STAT_ABORT;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end else begin
                        r_run_idx <= r_run_idx + RUN_WIDTH'(1);
                        r_state   <= ST_WAIT_START;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    perf_stat_acc #(
        .CNT_WIDTH (CNT_WIDTH),
        .RUN_WIDTH (RUN_WIDTH)
    ) u_stat_acc (
        .i_clk     (sys_clk),
        .i_rst     (sys_reset),
        .i_clr     (w_acc_clr),
        .i_upd     (w_acc_upd),
        .i_h2b     (w_h2b_smp),
        .i_h2c     (h2c_cyc_cnt),
        .o_h2c_min (res_h2c_min),
        .o_h2c_max (res_h2c_max),
        .o_h2c_sum (res_h2c_sum),
        .o_h2b_sum (res_h2b_sum)
    );

    assign busy       = r_busy;
    assign res_valid  = r_res_valid;
    assign run_idx    = r_run_idx;
    assign res_runs   = r_res_runs;
    assign res_status = r_status;

endmodule

// File: tb/tb_perf_run_ctrl.sv
module tb_perf_run_ctrl;

    localparam int CW = 28;
    localparam int RW = 8;
    localparam logic [CW-1:0] ONES = {CW{1'b1}};

    logic             sys_clk = 1'b0;
    logic             sys_reset;
    logic [RW-1:0]    cfg_runs;
    logic [CW-1:0]    cfg_timeout;
    logic             arm, abort;
    logic             h2b_start_pos, h2b_end_pos, h2c_end_pos;
    logic [CW-1:0]    h2b_cyc_cnt, h2c_cyc_cnt;
    logic             busy;
    logic [RW-1:0]    run_idx;
    logic             res_valid;
    logic             res_ready;
    logic [RW-1:0]    res_runs;
    logic [1:0]       res_status;
    logic [CW-1:0]    res_h2c_min, res_h2c_max;
    logic [CW+RW-1:0] res_h2c_sum, res_h2b_sum;

    int total = 0;
    int bad   = 0;

    perf_run_ctrl #(.CNT_WIDTH(CW), .RUN_WIDTH(RW)) dut (
        .sys_clk       (sys_clk),
        .sys_reset     (sys_reset),
        .cfg_runs      (cfg_runs),
        .cfg_timeout   (cfg_timeout),
        .arm           (arm),
        .abort         (abort),
        .h2b_start_pos (h2b_start_pos),
        .h2b_end_pos   (h2b_end_pos),
        .h2c_end_pos   (h2c_end_pos),
        .h2b_cyc_cnt   (h2b_cyc_cnt),
        .h2c_cyc_cnt   (h2c_cyc_cnt),
        .busy          (busy),
        .run_idx       (run_idx),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_runs      (res_runs),
        .res_status    (res_status),
        .res_h2c_min   (res_h2c_min),
        .res_h2c_max   (res_h2c_max),
        .res_h2c_sum   (res_h2c_sum),
        .res_h2b_sum   (res_h2b_sum)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_arm(input logic [RW-1:0] runs, input logic [CW-1:0] to);
        cfg_runs = runs; cfg_timeout = to; arm = 1'b1;
        tick;
        arm = 1'b0;
    endtask

    // From WAIT_START: start, h2b end, later h2c end. Returns in CAPTURE.
    // h2b count is corrupted after its latch cycle to prove it was latched.
    task automatic do_run(input logic [CW-1:0] b, input logic [CW-1:0] c);
        h2b_start_pos = 1'b1; tick; h2b_start_pos = 1'b0;
        tick;
        h2b_end_pos = 1'b1; h2b_start_pos = 1'b1; tick;
        h2b_end_pos = 1'b0; h2b_start_pos = 1'b0; h2b_cyc_cnt = b;
        tick;
        h2b_cyc_cnt = 28'h0BAD000;
        tick;
        h2c_end_pos = 1'b1; tick;
        h2c_end_pos = 1'b0; h2c_cyc_cnt = c;
    endtask

    task automatic handshake;
        res_ready = 1'b1; tick; res_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || run_idx !== '0 || res_runs !== '0 ||
            res_status !== 2'd0 || res_h2c_min !== ONES || res_h2c_max !== '0 ||
            res_h2c_sum !== '0 || res_h2b_sum !== '0) begin
            bad++;
            $display("FAIL reset: busy=%0b valid=%0b idx=%0d runs=%0d st=%0d min=%h max=%0d hs=%0d bs=%0d required 0 0 0 0 0 fffffff 0 0 0",
                     busy, res_valid, run_idx, res_runs, res_status, res_h2c_min, res_h2c_max, res_h2c_sum, res_h2b_sum);
        end
    endtask

    task automatic test_campaign;
        logic [CW-1:0] hc [3];
        logic [CW-1:0] hb [3];
        hc[0] = 100; hc[1] = 50; hc[2] = 75;
        hb[0] = 10;  hb[1] = 20; hb[2] = 30;
        do_arm(8'd3, '0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL arm_busy: got %0b required 1", busy); end
        for (int i = 0; i < 3; i++) begin
            do_run(hb[i], hc[i]);
            tick;
            h2c_cyc_cnt = 28'h0DEAD00;
            total++;
            if (res_runs !== RW'(i + 1)) begin
                bad++; $display("FAIL campaign_runs%0d: got %0d required %0d", i, res_runs, i + 1);
            end
            total++;
            if (res_valid !== (i == 2)) begin
                bad++; $display("FAIL campaign_valid%0d: got %0b required %0b", i, res_valid, i == 2);
            end
            if (i < 2) begin
                total++;
                if (run_idx !== RW'(i + 1)) begin
                    bad++; $display("FAIL campaign_idx%0d: got %0d required %0d", i, run_idx, i + 1);
                end
            end
        end
        total++;
        if (res_status !== 2'd0 || res_runs !== 8'd3 || res_h2c_min !== 28'd50 ||
            res_h2c_max !== 28'd100 || res_h2c_sum !== 36'd225 || res_h2b_sum !== 36'd60) begin
            bad++;
            $display("FAIL campaign_stats: st=%0d runs=%0d min=%0d max=%0d hs=%0d bs=%0d required 0 3 50 100 225 60",
                     res_status, res_runs, res_h2c_min, res_h2c_max, res_h2c_sum, res_h2b_sum);
        end
        handshake;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL campaign_done: busy=%0b valid=%0b required 0 0", busy, res_valid);
        end
    endtask

    task automatic test_same_cycle;
        do_arm(8'd1, '0);
        h2b_start_pos = 1'b1; tick; h2b_start_pos = 1'b0;
        tick;
        h2b_end_pos = 1'b1; h2c_end_pos = 1'b1; tick;
        h2b_end_pos = 1'b0; h2c_end_pos = 1'b0;
        h2b_cyc_cnt = 28'd7; h2c_cyc_cnt = 28'd40;
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL same_t1_valid: got %0b required 0", res_valid); end
        tick;
        h2b_cyc_cnt = 28'h0BAD000; h2c_cyc_cnt = 28'h0DEAD00;
        total++;
        if (res_valid !== 1'b1 || res_runs !== 8'd1 || res_h2c_min !== 28'd40 || res_h2c_max !== 28'd40 ||
            res_h2c_sum !== 36'd40 || res_h2b_sum !== 36'd7) begin
            bad++;
            $display("FAIL same_t2: valid=%0b runs=%0d min=%0d max=%0d hs=%0d bs=%0d required 1 1 40 40 40 7",
                     res_valid, res_runs, res_h2c_min, res_h2c_max, res_h2c_sum, res_h2b_sum);
        end
        handshake;
    endtask

    task automatic test_timeout;
        int early;
        do_arm(8'd2, 28'd20);
        do_run(28'd11, 28'd33);
        tick;
        h2b_start_pos = 1'b1; tick; h2b_start_pos = 1'b0;
        // now in RUN cycle 1; counter reaches 20 in cycle 21
        early = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (res_valid !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin bad++; $display("FAIL timeout_early: got %0d early valid cycles required 0", early); end
        tick;
        total++;
        if (res_valid !== 1'b1 || res_status !== 2'd1 || res_runs !== 8'd1 || res_h2c_min !== 28'd33 ||
            res_h2c_max !== 28'd33 || res_h2c_sum !== 36'd33 || res_h2b_sum !== 36'd11) begin
            bad++;
            $display("FAIL timeout_report: valid=%0b st=%0d runs=%0d min=%0d max=%0d hs=%0d bs=%0d required 1 1 1 33 33 33 11",
                     res_valid, res_status, res_runs, res_h2c_min, res_h2c_max, res_h2c_sum, res_h2b_sum);
        end
        handshake;
    endtask

    task automatic test_abort;
        do_arm(8'd4, '0);
        abort = 1'b1; tick; abort = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res_status !== 2'd2 || res_runs !== 8'd0 || res_h2c_min !== ONES ||
            res_h2c_max !== '0 || res_h2c_sum !== '0 || res_h2b_sum !== '0) begin
            bad++;
            $display("FAIL abort_wait: valid=%0b st=%0d runs=%0d min=%h max=%0d hs=%0d bs=%0d required 1 2 0 fffffff 0 0 0",
                     res_valid, res_status, res_runs, res_h2c_min, res_h2c_max, res_h2c_sum, res_h2b_sum);
        end
        handshake;
    endtask

    task automatic test_zero_runs_hold;
        int unstable;
        do_arm(8'd0, '0);
        arm = 1'b1; cfg_runs = 8'd5; tick; arm = 1'b0;
        total++;
        if (busy !== 1'b1 || run_idx !== 8'd0) begin
            bad++; $display("FAIL arm_busy_ignored: busy=%0b idx=%0d required 1 0", busy, run_idx);
        end
        do_run(28'd3, 28'd5);
        tick;
        h2c_cyc_cnt = 28'h0DEAD00;
        unstable = 0;
        for (int k = 0; k < 5; k++) begin
            abort = (k == 2);
            tick;
            if (res_valid !== 1'b1 || res_status !== 2'd0 || res_runs !== 8'd1 || res_h2c_min !== 28'd5 ||
                res_h2c_max !== 28'd5 || res_h2c_sum !== 36'd5 || res_h2b_sum !== 36'd3) unstable++;
        end
        abort = 1'b0;
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL zero_runs_hold: %0d unstable cycles, last valid=%0b st=%0d runs=%0d min=%0d required 1 0 1 5",
                     unstable, res_valid, res_status, res_runs, res_h2c_min);
        end
        arm = 1'b1; res_ready = 1'b1; tick; arm = 1'b0; res_ready = 1'b0;
        tick;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL arm_in_handshake: busy=%0b valid=%0b required 0 0", busy, res_valid);
        end
    endtask

    task automatic test_reset_mid;
        do_arm(8'd2, '0);
        do_run(28'd8, 28'd60);
        tick;
        h2b_start_pos = 1'b1; tick; h2b_start_pos = 1'b0;
        tick;
        #2 sys_reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || run_idx !== '0 || res_runs !== '0 ||
            res_h2c_min !== ONES || res_h2c_max !== '0 || res_h2c_sum !== '0 || res_h2b_sum !== '0) begin
            bad++;
            $display("FAIL reset_mid: busy=%0b valid=%0b idx=%0d runs=%0d min=%h max=%0d hs=%0d bs=%0d required reset values",
                     busy, res_valid, run_idx, res_runs, res_h2c_min, res_h2c_max, res_h2c_sum, res_h2b_sum);
        end
        tick;
        sys_reset = 1'b0;
        tick;
        do_arm(8'd1, '0);
        do_run(28'd4, 28'd9);
        tick;
        total++;
        if (res_valid !== 1'b1 || res_status !== 2'd0 || res_runs !== 8'd1 || res_h2c_min !== 28'd9 ||
            res_h2c_max !== 28'd9 || res_h2c_sum !== 36'd9 || res_h2b_sum !== 36'd4) begin
            bad++;
            $display("FAIL reset_clean: valid=%0b st=%0d runs=%0d min=%0d max=%0d hs=%0d bs=%0d required 1 0 1 9 9 9 4",
                     res_valid, res_status, res_runs, res_h2c_min, res_h2c_max, res_h2c_sum, res_h2b_sum);
        end
        handshake;
    endtask

    initial begin
        sys_reset = 1'b1; cfg_runs = '0; cfg_timeout = '0; arm = 1'b0; abort = 1'b0;
        h2b_start_pos = 1'b0; h2b_end_pos = 1'b0; h2c_end_pos = 1'b0;
        h2b_cyc_cnt = '0; h2c_cyc_cnt = '0; res_ready = 1'b0;
        tick; tick;
        test_reset;
        sys_reset = 1'b0;
        tick;
        test_campaign;
        test_same_cycle;
        test_timeout;
        test_abort;
        test_zero_runs_hold;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
